// File: rtl/scrambler.sv
// Bit-serial frame-synchronous scrambler for S(x) = x^7 + x^4 + 1.
// Each clock edge out of reset XORs one input bit with the LFSR keystream
// bit and advances the LFSR. The same block descrambles when it is seeded
// identically to the transmitter, because the keystream does not depend on
// the data.
module scrambler (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seed,
    input  logic       data_in,
    output logic       data_out
);

    // lfsr[6] is the oldest bit (x^7 tap); lfsr[3] is the x^4 tap.
    logic [6:0] lfsr;
    logic       fb;

    // Keystream bit, shared by the data path and the shift-in of the LFSR.
    always_comb begin
        fb = lfsr[6] ^ lfsr[3];
    end

    // Seeded LFSR and registered output. While reset is high the register
    // tracks seed, so a reset mid-frame discards everything immediately.
    // NOTE: non-blocking assignments here so lfsr and data_out both use the
    // pre-edge value of fb; blocking would let the shift corrupt the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr     <= seed;
            data_out <= 1'b0;
        end else begin
            lfsr     <= {lfsr[5:0], fb};
            data_out <= data_in ^ fb;
        end
    end

endmodule

// File: tb/tb_scrambler.sv
// Directed testbench for the x^7 + x^4 + 1 scrambler.
module tb_scrambler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reset2 = 1'b1;
    logic [6:0] seed = 7'b0;
    logic       data_in = 1'b0;
    logic       data_out;
    logic       data_out2;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic din;
        logic dout;
    } vec_t;

    vec_t vecs [14];
    logic [0:15] ref_ks;
    logic [0:15] ref_tail;
    logic        bits [202];

    always #5 clk = ~clk;

    scrambler dut (
        .clk      (clk),
        .reset    (reset),
        .seed     (seed),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // Second instance descrambles the output of the first.
    scrambler dut2 (
        .clk      (clk),
        .reset    (reset2),
        .seed     (seed),
        .data_in  (data_out),
        .data_out (data_out2)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [6:0] s);
        seed  = s;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_out", {31'b0, data_out}, 32'd0);
        check("reset_lfsr", {25'b0, dut.lfsr}, {25'b0, s});
        reset = 1'b0;
    endtask

    initial begin
        // Scenarios 1 and 2: seed 0101001, seven zeros then 1110100.
        vecs[0]  = '{1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0};
        ref_ks = 16'b0000111011110010;

        do_reset(7'b0101001);
        for (int i = 0; i < 14; i++) begin
            data_in = vecs[i].din;
            step();
            check($sformatf("vec%0d", i), {31'b0, data_out}, {31'b0, vecs[i].dout});
            if (i == 6) check("lfsr_after7", {25'b0, dut.lfsr}, {25'b0, 7'b1100111});
        end

        // Scenario 3: all-ones seed gives the reference keystream, period 127.
        do_reset(7'b1111111);
        data_in = 1'b0;
        for (int i = 0; i < 143; i++) begin
            step();
            if (i < 16) begin
                check($sformatf("ks%0d", i), {31'b0, data_out}, {31'b0, ref_ks[i]});
            end else if (i >= 127) begin
                ref_tail[i-127] = data_out;
            end
        end
        check("period127", {16'b0, ref_tail}, {16'b0, ref_ks});

        // Scenario 4: zero seed is a plain one-cycle delay.
        do_reset(7'b0000000);
        for (int i = 0; i < 24; i++) begin
            data_in = 1'($urandom_range(0, 1));
            step();
            check($sformatf("zero_seed%0d", i), {31'b0, data_out}, {31'b0, data_in});
        end
        check("zero_lfsr", {25'b0, dut.lfsr}, 32'd0);

        // Scenario 5: scrambler followed by descrambler restores the input.
        // The descrambler leaves reset one cycle later so its keystream lines
        // up with the first scrambled bit.
        seed   = 7'b1011101;
        reset  = 1'b1;
        reset2 = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 202; i++) begin
            bits[i] = (i < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            data_in = bits[i];
            step();
            if (i == 0) reset2 = 1'b0;
            if (i >= 1) check($sformatf("chain%0d", i - 1), {31'b0, data_out2}, {31'b0, bits[i-1]});
        end

        // Scenario 6: asynchronous reset mid-stream with a new seed.
        do_reset(7'b0101001);
        data_in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_async_out", {31'b0, data_out}, 32'd1);
        #2;
        seed  = 7'b1111111;
        reset = 1'b1;
        #1;
        check("async_out", {31'b0, data_out}, 32'd0);
        check("async_lfsr", {25'b0, dut.lfsr}, {25'b0, 7'b1111111});
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("after_async%0d", i), {31'b0, data_out}, {31'b0, ref_ks[i]});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/scrambler.md
Name: scrambler

Overview:
Bit-serial IEEE 802.11a/g-style frame-synchronous data scrambler using generator polynomial S(x) = x^7 + x^4 + 1.
- Processes one data bit per clock: XORs `data_in` with the LFSR keystream bit and returns a registered `data_out`.
- The 7-bit LFSR is initialised from `seed` during reset.
- Sits in the TX chain between MAC/PLCP bit source and convolutional encoder. Being self-synchronous to the seed, the same block also serves as the RX descrambler.

Parameters:
- None. Polynomial, width (7) and taps are fixed.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset; while high, LFSR is forced to `seed`.
- `seed`  input  7  LFSR initial value; `seed[6]` maps to register stage x^7, `seed[0]` to stage x^1.
- `data_in`  input  1  serial input bit, sampled on each rising edge while `reset` is low.
- `data_out`  output  1  registered scrambled bit.

Behaviour:
- Interface: one clock (`clk`); reset (`reset`) is asynchronous and active-high.
- State: 7-bit register `s[6:0]`, where `s[6]` is the oldest bit (x^7 tap) and `s[3]` is the x^4 tap.
- Reset:
  - While `reset`=1, `s` asynchronously follows `seed` and `data_out`=0.
  - `seed` must be held stable for the whole reset pulse.
  - Reset asserted mid-frame aborts the frame immediately and reloads the seed. No partial state is retained.
- Per rising edge with `reset`=0:
  - `fb` = `s[6]` XOR `s[3]`
  - `data_out` <= `data_in` XOR `fb`
  - `s` <= {`s[5:0]`, `fb`}
- Latency:
  - `data_out` reflects the `data_in` sampled at the previous rising edge (1-cycle latency).
  - The first valid output appears after the first edge following reset release.
- No enable or handshake: every clock edge out of reset consumes one bit and advances the LFSR.
- Keystream period is 127 for any nonzero seed.
- All-zero seed: LFSR locks at 0 and `fb`=0 forever, so `data_out` = `data_in` delayed by one cycle. This is legal and needs no special handling or flag.
- Self-inverse: two instances with equal seeds in series restore the original bit stream (2-cycle total latency).
- Reset deassertion is synchronised by the user. Release must not coincide with a `clk` rising edge.

Test Plan:
1. Reset with `seed`=7'b0101001, then 7 cycles of `data_in`=0 -> `data_out` sequence 1,1,0,0,1,1,1. After those 7 cycles, `s`=7'b1100111.
2. Continue from scenario 1 with `data_in`=1,1,1,0,1,0,0 -> `data_out`=0,1,0,1,1,1,0.
3. `seed`=7'b1111111, `data_in`=0 for 16 cycles -> `data_out`=0000111011110010 (802.11 reference keystream start). Running 127 cycles then repeats from the start (period check).
4. `seed`=7'b0000000, random `data_in` -> `data_out` equals `data_in` delayed by 1 cycle. `s` stays 0.
5. Two scrambler instances chained with the same seed (e.g. 7'b1011101), 200 random bits -> second output equals the input delayed by 2 cycles.
6. Assert `reset` asynchronously mid-stream (between clock edges) with a new seed -> `data_out` goes to 0 at once. After release, the output follows the new seed's keystream from its first bit; no clock edge is needed for the reset to take effect.
